param_sync_fifo: RTL
====================

// Module: param_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO and the successor to the fixed 8x8 FIFO.
//  Adds fill count, programmable almost-full and almost-empty flags,
//  sticky-free overflow/underflow error pulses, and a selectable
//  first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks and is driven by the fifo_if driver modport.
// PARAMETERS
//  DATA_WIDTH  8          word width in bits
//  DEPTH       8          number of entries; power of 2, >= 2
//  AF_LEVEL    DEPTH-2    almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL    1          almost_empty asserted when count <= AE_LEVEL
//  FWFT        0          0: registered read, 1 cycle latency; 1: head word visible on data_out
// PORTS
//  clk           in   1               rising-edge clock
//  rst           in   1               asynchronous, active-high reset
//  w_en          in   1               write request
//  data_in       in   DATA_WIDTH      write data
//  r_en          in   1               read request
//  data_out      out  DATA_WIDTH      read data
//  full          out  1               count == DEPTH
//  empty         out  1               count == 0
//  almost_full   out  1               count >= AF_LEVEL
//  almost_empty  out  1               count <= AE_LEVEL
//  count         out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
//  overflow      out  1               1-cycle pulse: write rejected
//  underflow     out  1               1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset values: rd_ptr = 0, wr_ptr = 0, count = 0, data_out = 0,
//    overflow = 0, underflow = 0. Hence empty = 1, almost_empty = 1,
//    full = 0, almost_full = 0. Memory contents are not reset.
//  - Reset is asynchronous: asserting rst mid-operation discards all
//    contents immediately. The first accepted write is at the first edge
//    after rst deasserts.
//  - Write accept: wa = w_en & ~full. On accept, mem[wr_ptr] <= data_in
//    and wr_ptr increments.
//  - Read accept: ra = r_en & ~empty. On accept, rd_ptr increments.
//  - full/empty are evaluated from registered count at the edge. So with
//    w_en and r_en both high when full, only the read is accepted. When
//    empty, only the write is accepted. No pass-through.
//  - Simultaneous wa and ra: count is unchanged, and both pointers advance.
//  - count update: count <= count + wa - ra.
//  - All flags decode combinationally from the registered count.
//    They therefore update in the cycle after the accepting edge.
//  - Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0
//    with no special case.
//  - overflow <= w_en & full, and underflow <= r_en & empty. Each is
//    high for exactly the cycle after the rejected request, with no
//    state change.
//  - FWFT = 0: on ra, data_out <= mem[rd_ptr], valid in the cycle after
//    the accepting edge. data_out otherwise holds its last value.
//  - FWFT = 1: data_out = mem[rd_ptr] (combinational read), valid
//    whenever empty = 0. ra pops the head. With empty = 1, data_out is
//    don't-care.
//  - Elaboration checks: DEPTH must be a power of 2 and >= 2, and
//    0 <= AE_LEVEL < AF_LEVEL <= DEPTH. Any violation is a $fatal.
// STRUCTURE
//  - Package fifo_pkg holds:
//    - default DATA_WIDTH and DEPTH
//    - localparam-style function addr_w(depth) = $clog2(depth)
//    - typedef for count width
//  - Sub-module fifo_mem: DEPTH x DATA_WIDTH, one synchronous write port
//    and one asynchronous read port. The top level owns pointers, count,
//    flags and the FWFT mux.
//  - fifo_if gains almost_full, almost_empty, count, overflow and
//    underflow, as inputs to the monitor clocking block.
// TESTING (DATA_WIDTH = 8, DEPTH = 8, AF_LEVEL = 6, AE_LEVEL = 1)
//  1. Reset, then write 0x01..0x08, then read 8 times with FWFT = 0.
//     Required response: data_out = 0x01..0x08, each one cycle after its
//     read. full = 1 after the 8th write. count steps 0..8..0.
//     almost_full rises at count = 6. almost_empty is high at count <= 1.
//  2. Full FIFO, pulse w_en with 0xAA. Required response: overflow is
//     high for 1 cycle, count stays 8, and the next 8 reads contain
//     no 0xAA.
//  3. Empty FIFO, pulse r_en. Required response: underflow is high for
//     1 cycle, count stays 0, and data_out is unchanged.
//  4. count = 4, w_en = r_en = 1 for 20 cycles, writing an incrementing
//     pattern. Required response: count stays 4, pointers wrap twice,
//     and read data is in order with no loss.
//  5. FWFT = 1: write 0x5A to an empty FIFO. Required response:
//     data_out = 0x5A in the cycle empty falls, with no r_en. After one
//     r_en, empty = 1.
//  6. Assert rst asynchronously mid-cycle with count = 5. Required
//     response: before the next clk edge, count = 0, empty = 1 and
//     data_out = 0x00. Then write 0x33 and read it back correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the parametrised single-clock FIFO.
// No logic of its own; imported by fifo_mem and param_sync_fifo.
// Contents: default DATA_WIDTH/DEPTH, addr_w() pointer-width helper, count_t.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  // Pointer width for a power-of-2 depth.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy type for the default depth: 0..DEF_DEPTH needs one extra bit.
  typedef logic [$clog2(DEF_DEPTH):0] count_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: DEPTH x DATA_WIDTH, not reset.
// Latency: write lands at the clock edge; read is combinational from raddr.
// Backpressure: none here; the owner gates we against full.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with fill count, almost flags, error pulses and optional FWFT.
// Latency: FWFT=0 data_out one cycle after the accepting read edge; FWFT=1 head word shown combinationally.
// Backpressure: writes dropped when full (overflow pulse), reads dropped when empty (underflow pulse).
// Ports: clk, rst (async, active high), w_en/data_in, r_en/data_out,
//        full/empty/almost_full/almost_empty/count status, overflow/underflow pulses.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = AW + 1;

  // Parameter sanity: reject bad configurations at elaboration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "param_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
    $fatal(1, "param_sync_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count_q;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   wa;
  logic                   ra;

  // Flags come from the registered count only, so a read never frees a
  // slot for a write in the same cycle (and vice versa): no pass-through.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;

  assign wa = w_en & ~full;
  assign ra = r_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so wrap is natural overflow.
      if (wa) wr_ptr <= wr_ptr + AW'(1);
      if (ra) rd_ptr <= rd_ptr + AW'(1);
      case ({wa, ra})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow  <= w_en & full;
      underflow <= r_en & empty;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wa),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  if (FWFT) begin : g_fwft
    // Head word always on the output; meaningless while empty.
    assign data_out = rd_data;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] dout_q;

    // Holds the last popped word until the next accepted read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (ra) begin
        dout_q <= rd_data;
      end
    end

    assign data_out = dout_q;
  end

endmodule
